// File: rtl/trap_pkg.sv
// Shared definitions for the M/S-mode trap controller: sequencer states, privilege
// encodings, mstatus field positions and standard interrupt cause codes.
package trap_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_COMMIT   = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    localparam int MS_SIE    = 1;
    localparam int MS_MIE    = 3;
    localparam int MS_SPIE   = 5;
    localparam int MS_MPIE   = 7;
    localparam int MS_SPP    = 8;
    localparam int MS_MPP_LO = 11;
    localparam int MS_MPP_HI = 12;

    localparam logic [5:0] CAUSE_ILLEGAL_INSTR = 6'd2;
    localparam logic [5:0] CAUSE_SSI = 6'd1;
    localparam logic [5:0] CAUSE_MSI = 6'd3;
    localparam logic [5:0] CAUSE_STI = 6'd5;
    localparam logic [5:0] CAUSE_MTI = 6'd7;
    localparam logic [5:0] CAUSE_SEI = 6'd9;
    localparam logic [5:0] CAUSE_MEI = 6'd11;

    localparam int STD_IRQ_COUNT = 6;
    localparam int FIRST_PLATFORM_IRQ = 12;

    // Rank 0 is the highest-priority standard interrupt line.
    function automatic int std_irq_line(input int rank);
        case (rank)
            0:       return int'(CAUSE_MEI);
            1:       return int'(CAUSE_MSI);
            2:       return int'(CAUSE_MTI);
            3:       return int'(CAUSE_SEI);
            4:       return int'(CAUSE_SSI);
            default: return int'(CAUSE_STI);
        endcase
    endfunction

endpackage

// File: rtl/trap_irq_arbiter.sv
// Combinational interrupt selector: resolves each line's target mode, checks whether it is
// takeable at the current privilege, and picks the highest-priority takeable line.
module trap_irq_arbiter
    import trap_pkg::*;
#(
    parameter int NUM_IRQ    = 16,
    parameter bit SUPERVISOR = 1'b1
) (
    input  logic [NUM_IRQ-1:0] irq_masked,
    input  logic [1:0]         priv_lvl,
    input  logic               mstatus_mie,
    input  logic               mstatus_sie,
    input  logic [NUM_IRQ-1:0] mideleg,
    output logic               irq_valid,
    output logic [5:0]         irq_code,
    output logic               irq_to_s
);

    logic [NUM_IRQ-1:0] to_s;
    logic [NUM_IRQ-1:0] takeable;

    always_comb begin
        to_s     = '0;
        takeable = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            to_s[i] = SUPERVISOR && mideleg[i] && (priv_lvl != PRIV_M);
            if (to_s[i]) begin
                takeable[i] = irq_masked[i] &&
                              ((priv_lvl == PRIV_U) || ((priv_lvl == PRIV_S) && mstatus_sie));
            end else begin
                takeable[i] = irq_masked[i] && ((priv_lvl < PRIV_M) || mstatus_mie);
            end
        end
    end

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        irq_valid = 1'b0;
        irq_code  = '0;
        irq_to_s  = 1'b0;
        for (int i = NUM_IRQ - 1; i >= FIRST_PLATFORM_IRQ; i--) begin
            if (takeable[i]) begin
                irq_valid = 1'b1;
                irq_code  = 6'(i);
                irq_to_s  = to_s[i];
            end
        end
        for (int k = STD_IRQ_COUNT - 1; k >= 0; k--) begin
            if (takeable[std_irq_line(k)]) begin
                irq_valid = 1'b1;
                irq_code  = 6'(std_irq_line(k));
                irq_to_s  = to_s[std_irq_line(k)];
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// M/S-mode trap controller: arbitrates exceptions, interrupts and xRET, computes the CSR
// update set, and sequences IDLE -> COMMIT (CSR write pulse) -> REDIRECT (fetch handshake).
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int NUM_IRQ    = 16,
    parameter bit SUPERVISOR = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               exc_valid,
    input  logic [5:0]         exc_code,
    input  logic [XLEN-1:0]    exc_tval,
    input  logic [XLEN-1:0]    exc_pc,
    input  logic [NUM_IRQ-1:0] irq_pending,
    input  logic [NUM_IRQ-1:0] irq_enable,
    input  logic               mret,
    input  logic               sret,
    input  logic [1:0]         priv_lvl,
    input  logic [XLEN-1:0]    mstatus_in,
    input  logic [XLEN-1:0]    mtvec,
    input  logic [XLEN-1:0]    stvec,
    input  logic [XLEN-1:0]    mepc,
    input  logic [XLEN-1:0]    sepc,
    input  logic [XLEN-1:0]    medeleg,
    input  logic [XLEN-1:0]    mideleg,
    input  logic               redirect_ready,
    output logic               busy,
    output logic               csr_we_m,
    output logic               csr_we_s,
    output logic               csr_we_ret,
    output logic [XLEN-1:0]    epc_next,
    output logic [XLEN-1:0]    cause_next,
    output logic [XLEN-1:0]    tval_next,
    output logic [XLEN-1:0]    mstatus_next,
    output logic [1:0]         priv_next,
    output logic               redirect_valid,
    output logic [XLEN-1:0]    redirect_pc
);

    logic [1:0]      state_q, state_d;
    logic            csr_we_m_q, csr_we_m_d;
    logic            csr_we_s_q, csr_we_s_d;
    logic            csr_we_ret_q, csr_we_ret_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic [XLEN-1:0] mstatus_q, mstatus_d;
    logic [1:0]      priv_q, priv_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

    logic            arb_valid;
    logic [5:0]      arb_code;
    logic            arb_to_s;

    logic            trap_take;
    logic            trap_irq;
    logic [5:0]      trap_code;
    logic [XLEN-1:0] trap_tval;
    logic            trap_to_s;
    logic            ret_m;
    logic            ret_s;
    logic [XLEN-1:0] ms;

    trap_irq_arbiter #(
        .NUM_IRQ    (NUM_IRQ),
        .SUPERVISOR (SUPERVISOR)
    ) u_arb (
        .irq_masked  (irq_pending & irq_enable),
        .priv_lvl    (priv_lvl),
        .mstatus_mie (mstatus_in[MS_MIE]),
        .mstatus_sie (mstatus_in[MS_SIE]),
        .mideleg     (mideleg[NUM_IRQ-1:0]),
        .irq_valid   (arb_valid),
        .irq_code    (arb_code),
        .irq_to_s    (arb_to_s)
    );

    // mideleg bits above the implemented interrupt lines have no effect.
    if (NUM_IRQ < XLEN) begin : g_mideleg_hi
        logic unused_mideleg_hi;
        assign unused_mideleg_hi = ^mideleg[XLEN-1:NUM_IRQ];
    end

    function automatic logic [XLEN-1:0] trap_vector(input logic [XLEN-1:0] tvec,
                                                    input logic is_irq,
                                                    input logic [5:0] code);
        logic [XLEN-1:0] base;
        base = {tvec[XLEN-1:2], 2'b00};
        if (is_irq && (tvec[1:0] == 2'b01)) begin
            base = base + {{(XLEN-8){1'b0}}, code, 2'b00};
        end
        return base;
    endfunction

    function automatic logic [XLEN-1:0] cause_word(input logic is_irq, input logic [5:0] code);
        return {is_irq, {(XLEN-7){1'b0}}, code};
    endfunction

    always_comb begin
        state_d       = state_q;
        csr_we_m_d    = 1'b0;
        csr_we_s_d    = 1'b0;
        csr_we_ret_d  = 1'b0;
        epc_d         = epc_q;
        cause_d       = cause_q;
        tval_d        = tval_q;
        mstatus_d     = mstatus_q;
        priv_d        = priv_q;
        redirect_pc_d = redirect_pc_q;
        trap_take     = 1'b0;
        trap_irq      = 1'b0;
        trap_code     = '0;
        trap_tval     = '0;
        trap_to_s     = 1'b0;
        ret_m         = 1'b0;
        ret_s         = 1'b0;
        ms            = mstatus_in;

        case (state_q)
            ST_IDLE: begin
                if (exc_valid) begin
                    trap_take = 1'b1;
                    trap_code = exc_code;
                    trap_tval = exc_tval;
                end else if (arb_valid) begin
                    trap_take = 1'b1;
                    trap_irq  = 1'b1;
                    trap_code = arb_code;
                end else if (mret) begin
                    if (priv_lvl == PRIV_M) begin
                        ret_m = 1'b1;
                    end else begin
                        trap_take = 1'b1;
                        trap_code = CAUSE_ILLEGAL_INSTR;
                    end
                end else if (sret) begin
                    if (SUPERVISOR && (priv_lvl >= PRIV_S)) begin
                        ret_s = 1'b1;
                    end else begin
                        trap_take = 1'b1;
                        trap_code = CAUSE_ILLEGAL_INSTR;
                    end
                end

                if (trap_irq) begin
                    trap_to_s = arb_to_s;
                end else begin
                    trap_to_s = SUPERVISOR && medeleg[trap_code] && (priv_lvl != PRIV_M);
                end

                if (trap_take) begin
                    state_d = ST_COMMIT;
                    epc_d   = exc_pc;
                    cause_d = cause_word(trap_irq, trap_code);
                    tval_d  = trap_tval;
                    if (trap_to_s) begin
                        ms[MS_SPIE]   = ms[MS_SIE];
                        ms[MS_SIE]    = 1'b0;
                        ms[MS_SPP]    = priv_lvl[0];
                        priv_d        = PRIV_S;
                        csr_we_s_d    = 1'b1;
                        redirect_pc_d = trap_vector(stvec, trap_irq, trap_code);
                    end else begin
                        ms[MS_MPIE]              = ms[MS_MIE];
                        ms[MS_MIE]               = 1'b0;
                        ms[MS_MPP_HI:MS_MPP_LO]  = priv_lvl;
                        priv_d                   = PRIV_M;
                        csr_we_m_d               = 1'b1;
                        redirect_pc_d            = trap_vector(mtvec, trap_irq, trap_code);
                    end
                    mstatus_d = ms;
                end else if (ret_m) begin
                    state_d                 = ST_COMMIT;
                    priv_d                  = mstatus_in[MS_MPP_HI:MS_MPP_LO];
                    ms[MS_MIE]              = ms[MS_MPIE];
                    ms[MS_MPIE]             = 1'b1;
                    ms[MS_MPP_HI:MS_MPP_LO] = PRIV_U;
                    mstatus_d               = ms;
                    redirect_pc_d           = mepc;
                    csr_we_ret_d            = 1'b1;
                end else if (ret_s) begin
                    state_d       = ST_COMMIT;
                    priv_d        = {1'b0, mstatus_in[MS_SPP]};
                    ms[MS_SIE]    = ms[MS_SPIE];
                    ms[MS_SPIE]   = 1'b1;
                    ms[MS_SPP]    = 1'b0;
                    mstatus_d     = ms;
                    redirect_pc_d = sepc;
                    csr_we_ret_d  = 1'b1;
                end
            end
            ST_COMMIT:   state_d = ST_REDIRECT;
            ST_REDIRECT: if (redirect_ready) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            csr_we_m_q    <= 1'b0;
            csr_we_s_q    <= 1'b0;
            csr_we_ret_q  <= 1'b0;
            epc_q         <= '0;
            cause_q       <= '0;
            tval_q        <= '0;
            mstatus_q     <= '0;
            priv_q        <= PRIV_M;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            csr_we_m_q    <= csr_we_m_d;
            csr_we_s_q    <= csr_we_s_d;
            csr_we_ret_q  <= csr_we_ret_d;
            epc_q         <= epc_d;
            cause_q       <= cause_d;
            tval_q        <= tval_d;
            mstatus_q     <= mstatus_d;
            priv_q        <= priv_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign redirect_valid = (state_q == ST_REDIRECT);
    assign csr_we_m       = csr_we_m_q;
    assign csr_we_s       = csr_we_s_q;
    assign csr_we_ret     = csr_we_ret_q;
    assign epc_next       = epc_q;
    assign cause_next     = cause_q;
    assign tval_next      = tval_q;
    assign mstatus_next   = mstatus_q;
    assign priv_next      = priv_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed testbench for trap_ctrl: hand-computed trap entry, xRET, priority, backpressure
// and mid-sequence reset scenarios.
module tb_trap_ctrl;

    localparam int XLEN    = 64;
    localparam int NUM_IRQ = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               exc_valid;
    logic [5:0]         exc_code;
    logic [XLEN-1:0]    exc_tval;
    logic [XLEN-1:0]    exc_pc;
    logic [NUM_IRQ-1:0] irq_pending;
    logic [NUM_IRQ-1:0] irq_enable;
    logic               mret;
    logic               sret;
    logic [1:0]         priv_lvl;
    logic [XLEN-1:0]    mstatus_in;
    logic [XLEN-1:0]    mtvec;
    logic [XLEN-1:0]    stvec;
    logic [XLEN-1:0]    mepc;
    logic [XLEN-1:0]    sepc;
    logic [XLEN-1:0]    medeleg;
    logic [XLEN-1:0]    mideleg;
    logic               redirect_ready;
    logic               busy;
    logic               csr_we_m;
    logic               csr_we_s;
    logic               csr_we_ret;
    logic [XLEN-1:0]    epc_next;
    logic [XLEN-1:0]    cause_next;
    logic [XLEN-1:0]    tval_next;
    logic [XLEN-1:0]    mstatus_next;
    logic [1:0]         priv_next;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;

    int err_cnt = 0;
    int chk_cnt = 0;

    trap_ctrl #(
        .XLEN       (XLEN),
        .NUM_IRQ    (NUM_IRQ),
        .SUPERVISOR (1'b1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .exc_valid      (exc_valid),
        .exc_code       (exc_code),
        .exc_tval       (exc_tval),
        .exc_pc         (exc_pc),
        .irq_pending    (irq_pending),
        .irq_enable     (irq_enable),
        .mret           (mret),
        .sret           (sret),
        .priv_lvl       (priv_lvl),
        .mstatus_in     (mstatus_in),
        .mtvec          (mtvec),
        .stvec          (stvec),
        .mepc           (mepc),
        .sepc           (sepc),
        .medeleg        (medeleg),
        .mideleg        (mideleg),
        .redirect_ready (redirect_ready),
        .busy           (busy),
        .csr_we_m       (csr_we_m),
        .csr_we_s       (csr_we_s),
        .csr_we_ret     (csr_we_ret),
        .epc_next       (epc_next),
        .cause_next     (cause_next),
        .tval_next      (tval_next),
        .mstatus_next   (mstatus_next),
        .priv_next      (priv_next),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {csr_we_m, csr_we_s, csr_we_ret} as one value
    task automatic chk_we(input string tag, input logic [2:0] exp);
        chk(tag, 64'({csr_we_m, csr_we_s, csr_we_ret}), 64'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_events();
        exc_valid   = 1'b0;
        mret        = 1'b0;
        sret        = 1'b0;
        irq_pending = '0;
    endtask

    task automatic clear_inputs();
        clear_events();
        exc_code       = '0;
        exc_tval       = '0;
        exc_pc         = '0;
        irq_enable     = '0;
        priv_lvl       = 2'b11;
        mstatus_in     = '0;
        mtvec          = 64'h100;
        stvec          = 64'h400;
        mepc           = '0;
        sepc           = '0;
        medeleg        = '0;
        mideleg        = '0;
        redirect_ready = 1'b1;
    endtask

    // Event presented now is sampled at the next edge; returns in COMMIT.
    task automatic launch();
        step();
        clear_events();
    endtask

    // From COMMIT: check the REDIRECT cycle, then the return to IDLE.
    task automatic redirect_phase(input string tag, input logic [63:0] exp_pc);
        step();
        chk({tag, "_rv"}, 64'(redirect_valid), 64'd1);
        chk({tag, "_rpc"}, redirect_pc, exp_pc);
        chk_we({tag, "_we_off"}, 3'b000);
        step();
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk_we("rst_we", 3'b000);
        chk("rst_rv", 64'(redirect_valid), 64'd0);
        chk("rst_priv", 64'(priv_next), 64'd3);
        chk("rst_cause", cause_next, 64'd0);
        chk("rst_rpc", redirect_pc, 64'd0);
        rst = 1'b0;
        step();

        // Illegal instruction from U, not delegated
        priv_lvl = 2'b00; exc_valid = 1'b1; exc_code = 6'd2;
        exc_tval = 64'hDEAD; exc_pc = 64'h1000;
        launch();
        chk_we("t1_we", 3'b100);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_rv_commit", 64'(redirect_valid), 64'd0);
        chk("t1_cause", cause_next, 64'h2);
        chk("t1_tval", tval_next, 64'hDEAD);
        chk("t1_epc", epc_next, 64'h1000);
        chk("t1_priv", 64'(priv_next), 64'd3);
        chk("t1_mstatus", mstatus_next, 64'h0);
        redirect_phase("t1", 64'h100);

        // Vectored M interrupt, 11 beats 7
        clear_inputs();
        priv_lvl = 2'b11; mstatus_in = 64'h8; mtvec = 64'h201;
        irq_pending = 16'h0880; irq_enable = 16'hFFFF; exc_pc = 64'h1234;
        launch();
        chk_we("t2_we", 3'b100);
        chk("t2_cause", cause_next, 64'h8000_0000_0000_000B);
        chk("t2_tval", tval_next, 64'h0);
        chk("t2_mstatus", mstatus_next, 64'h1880);
        redirect_phase("t2", 64'h22C);

        // M-mode interrupt with MIE clear is not taken
        clear_inputs();
        priv_lvl = 2'b11; mstatus_in = 64'h0;
        irq_pending = 16'h0080; irq_enable = 16'hFFFF;
        step();
        chk("t2m_busy", 64'(busy), 64'd0);
        chk_we("t2m_we", 3'b000);

        // Delegated S interrupt from U, vectored stvec
        clear_inputs();
        priv_lvl = 2'b00; mideleg = 64'h20; stvec = 64'h401;
        irq_pending = 16'h0020; irq_enable = 16'hFFFF;
        launch();
        chk_we("t2s_we", 3'b010);
        chk("t2s_cause", cause_next, 64'h8000_0000_0000_0005);
        chk("t2s_priv", 64'(priv_next), 64'd1);
        redirect_phase("t2s", 64'h414);

        // Delegated ecall from U
        clear_inputs();
        priv_lvl = 2'b00; medeleg = 64'h100; mstatus_in = 64'h2;
        exc_valid = 1'b1; exc_code = 6'd8; exc_pc = 64'h2000;
        launch();
        chk_we("t3_we", 3'b010);
        chk("t3_cause", cause_next, 64'h8);
        chk("t3_priv", 64'(priv_next), 64'd1);
        chk("t3_mstatus", mstatus_next, 64'h20);
        chk("t3_epc", epc_next, 64'h2000);
        redirect_phase("t3", 64'h400);

        // Same ecall from M is not delegated
        clear_inputs();
        priv_lvl = 2'b11; medeleg = 64'h100; mstatus_in = 64'h2;
        exc_valid = 1'b1; exc_code = 6'd8;
        launch();
        chk_we("t3m_we", 3'b100);
        chk("t3m_priv", 64'(priv_next), 64'd3);
        chk("t3m_mstatus", mstatus_next, 64'h1802);
        redirect_phase("t3m", 64'h100);

        // MRET from M with MPP=S, MPIE=1
        clear_inputs();
        priv_lvl = 2'b11; mstatus_in = 64'h880; mepc = 64'h80; mret = 1'b1;
        launch();
        chk_we("t4_we", 3'b001);
        chk("t4_priv", 64'(priv_next), 64'd1);
        chk("t4_mstatus", mstatus_next, 64'h88);
        redirect_phase("t4", 64'h80);

        // MRET from U is an illegal instruction
        clear_inputs();
        priv_lvl = 2'b00; exc_pc = 64'h3000; exc_tval = 64'h55; mret = 1'b1;
        launch();
        chk_we("t4i_we", 3'b100);
        chk("t4i_cause", cause_next, 64'h2);
        chk("t4i_tval", tval_next, 64'h0);
        chk("t4i_epc", epc_next, 64'h3000);
        redirect_phase("t4i", 64'h100);

        // SRET from S with SPP=U, SPIE=1
        clear_inputs();
        priv_lvl = 2'b01; mstatus_in = 64'h20; sepc = 64'h500; sret = 1'b1;
        launch();
        chk_we("t4s_we", 3'b001);
        chk("t4s_priv", 64'(priv_next), 64'd0);
        chk("t4s_mstatus", mstatus_next, 64'h22);
        redirect_phase("t4s", 64'h500);

        // Exception + interrupt + mret together, then fetch backpressure
        clear_inputs();
        priv_lvl = 2'b11; mstatus_in = 64'h8; irq_pending = 16'h0008; irq_enable = 16'hFFFF;
        mret = 1'b1; exc_valid = 1'b1; exc_code = 6'd2; exc_tval = 64'h77; exc_pc = 64'h4000;
        redirect_ready = 1'b0;
        launch();
        chk_we("t5_we", 3'b100);
        chk("t5_cause", cause_next, 64'h2);
        chk("t5_mstatus", mstatus_next, 64'h1880);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_rv", 64'(redirect_valid), 64'd1);
            chk("t5_hold_busy", 64'(busy), 64'd1);
            chk("t5_hold_rpc", redirect_pc, 64'h100);
            chk_we("t5_hold_we", 3'b000);
            chk("t5_hold_cause", cause_next, 64'h2);
            exc_valid = 1'b1; exc_code = 6'd5;
            step();
        end
        exc_valid = 1'b0;
        redirect_ready = 1'b1;
        chk("t5_rv_last", 64'(redirect_valid), 64'd1);
        step();
        chk("t5_idle", 64'(busy), 64'd0);
        chk("t5_rv_off", 64'(redirect_valid), 64'd0);
        chk_we("t5_we_off", 3'b000);

        // Reset during COMMIT aborts the sequence
        clear_inputs();
        priv_lvl = 2'b00; exc_valid = 1'b1; exc_code = 6'd2; exc_pc = 64'h6000;
        launch();
        chk_we("t6_we_commit", 3'b100);
        rst = 1'b1;
        #1;
        chk("t6_busy", 64'(busy), 64'd0);
        chk_we("t6_we", 3'b000);
        chk("t6_priv", 64'(priv_next), 64'd3);
        chk("t6_epc", epc_next, 64'h0);
        chk("t6_mstatus", mstatus_next, 64'h0);
        chk("t6_rpc", redirect_pc, 64'h0);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_no_rv", 64'(redirect_valid), 64'd0);
            chk("t6_no_busy", 64'(busy), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
